sys_bus_ctrl: RTL and testbench

//  Parametrised multi-master bus controller for the compy system bus. Arbitrates
//  N masters (cornet_cpu, chroni DMA, future blitter) onto one synchronous memory

---
 rtl/sys_bus_ctrl_pkg.sv | 25 ++
 rtl/bus_rr_arbiter.sv | 47 ++++
 rtl/sys_bus_ctrl.sv | 159 +++++++++++++++
 tb/tb_sys_bus_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_ctrl_pkg.sv
// Shared definitions for the compy system bus controller: arbitration modes,
// FSM state codes and sizing helpers.
package sys_bus_ctrl_pkg;

   localparam int MAX_MASTERS     = 8;
   localparam int MAX_READ_LAT    = 4;
   localparam int MAX_WAIT_STATES = 15;

   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

   typedef enum logic [1:0] {
      BUS_IDLE   = 2'd0,
      BUS_ACCESS = 2'd1,
      BUS_WAIT   = 2'd2
   } bus_state_t;

   // Index width that stays legal for a single master.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CNT_W = $clog2(MAX_READ_LAT + MAX_WAIT_STATES + 1);

endpackage

// File: rtl/bus_rr_arbiter.sv
// Combinational arbiter: picks one requester from a pending vector, either lowest
// index first or round-robin starting just after the previous grant.
module bus_rr_arbiter
   import sys_bus_ctrl_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  pend,
   input  logic          mode,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_vld
);

   logic [IW-1:0] rr_idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      rr_idx    = '0;
      case (mode)
         ARB_FIXED: begin
            for (int k = 0; k < N; k++) begin
               if (!grant_vld && pend[IW'(k)]) begin
                  grant_vld = 1'b1;
                  grant_idx = IW'(k);
               end
            end
         end
         default: begin
            // k = N brings the search back to the last winner itself.
            for (int k = 1; k <= N; k++) begin
               rr_idx = IW'((int'(last) + k) % N);
               if (!grant_vld && pend[rr_idx]) begin
                  grant_vld = 1'b1;
                  grant_idx = rr_idx;
               end
            end
         end
      endcase
      if (grant_vld) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/sys_bus_ctrl.sv
// Multi-master bus controller: captures pulse requests into per-master slots and
// serialises them onto one synchronous memory port with configurable latency.
module sys_bus_ctrl
   import sys_bus_ctrl_pkg::*;
#(
   parameter int N_MASTERS    = 2,
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 8,
   parameter int READ_LATENCY = 1,
   parameter int WAIT_STATES  = 0,
   parameter int ARB_MODE     = 0
) (
   input  logic                          sys_clk,
   input  logic                          reset_n,
   input  logic [N_MASTERS-1:0]          m_req,
   input  logic [N_MASTERS-1:0]          m_we,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
   output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
   output logic [N_MASTERS-1:0]          m_ready,
   output logic [N_MASTERS-1:0]          m_proto_err,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata
);

   localparam int IW = idx_w(N_MASTERS);

   if (N_MASTERS < 1 || N_MASTERS > MAX_MASTERS) begin : g_bad_masters
      $error("sys_bus_ctrl: N_MASTERS out of range");
   end

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } slot_t;

   slot_t      [N_MASTERS-1:0]             slot;
   slot_t                                  nxt_slot;
   logic       [N_MASTERS-1:0][ADDR_W-1:0] addr_a;
   logic       [N_MASTERS-1:0][DATA_W-1:0] wdata_a;
   logic       [N_MASTERS-1:0][DATA_W-1:0] rdata_q;

   bus_state_t             state;
   logic [IW-1:0]          cur;
   logic [IW-1:0]          rr_ptr;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       access_cnt;
   logic [N_MASTERS-1:0]   pending;
   logic [N_MASTERS-1:0]   cap;
   logic [N_MASTERS-1:0]   err;
   logic [N_MASTERS-1:0]   cur_oh;
   logic [N_MASTERS-1:0]   done_oh;
   logic [N_MASTERS-1:0]   cand;
   logic [N_MASTERS-1:0]   gnt;
   logic [IW-1:0]          gnt_idx;
   logic                   gnt_vld;
   logic                   done;

   assign addr_a  = m_addr;
   assign wdata_a = m_wdata;
   assign m_rdata = rdata_q;

   always_comb begin
      cap         = m_req & m_ready;
      err         = m_req & ~m_ready;
      cur_oh      = '0;
      cur_oh[cur] = 1'b1;
      access_cnt  = slot[cur].we ? CNT_W'(WAIT_STATES)
                                 : CNT_W'(READ_LATENCY + WAIT_STATES);
      done        = ((state == BUS_ACCESS) && (access_cnt == '0)) ||
                    ((state == BUS_WAIT) && (cnt == CNT_W'(1)));
      done_oh     = done ? cur_oh : '0;
      // A master captured this edge competes alongside those already waiting.
      cand        = (pending & ~done_oh) | cap;
   end

   bus_rr_arbiter #(
      .N  (N_MASTERS),
      .IW (IW)
   ) u_arb (
      .pend      (cand),
      .mode      ((ARB_MODE != 0) ? ARB_RR : ARB_FIXED),
      .last      (rr_ptr),
      .grant     (gnt),
      .grant_idx (gnt_idx),
      .grant_vld (gnt_vld)
   );

   // A freshly captured winner has not reached its slot yet; take it from the ports.
   always_comb begin
      if (|(cap & gnt))
         nxt_slot = '{we: m_we[gnt_idx], addr: addr_a[gnt_idx], wdata: wdata_a[gnt_idx]};
      else
         nxt_slot = slot[gnt_idx];
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= BUS_IDLE;
         cur         <= '0;
         rr_ptr      <= '0;
         cnt         <= '0;
         pending     <= '0;
         slot        <= '0;
         rdata_q     <= '0;
         m_ready     <= '1;
         m_proto_err <= '0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         m_proto_err <= m_proto_err | err;
         pending     <= (pending | cap) & ~done_oh;
         m_ready     <= (m_ready & ~cap) | done_oh;

         for (int i = 0; i < N_MASTERS; i++) begin
            if (cap[i]) slot[i] <= '{we: m_we[i], addr: addr_a[i], wdata: wdata_a[i]};
         end

         if (done && !slot[cur].we) rdata_q[cur] <= mem_rdata;

         case (state)
            BUS_ACCESS: begin
               if (access_cnt != '0) begin
                  state <= BUS_WAIT;
                  cnt   <= access_cnt;
               end
            end
            BUS_WAIT: begin
               if (!done) cnt <= cnt - CNT_W'(1);
            end
            default: ;
         endcase

         // Next grant launches on the completion edge itself, so no idle bubble.
         if (state == BUS_IDLE || done) begin
            if (gnt_vld) begin
               state     <= BUS_ACCESS;
               cur       <= gnt_idx;
               rr_ptr    <= gnt_idx;
               mem_en    <= 1'b1;
               mem_we    <= nxt_slot.we;
               mem_addr  <= nxt_slot.addr;
               mem_wdata <= nxt_slot.wdata;
            end else begin
               state <= BUS_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Directed bench for sys_bus_ctrl: three configurations (defaults, slow memory,
// three-master round-robin) each with a small behavioural memory model.
module tb_sys_bus_ctrl;

   logic sys_clk = 1'b0;
   logic reset_n;
   always #5 sys_clk = ~sys_clk;

   int passed = 0;
   int total  = 0;

   // Instance A: defaults
   logic [1:0]  a_req, a_we, a_ready, a_err;
   logic [31:0] a_addr;
   logic [15:0] a_wdata, a_rdata;
   logic        a_mem_en, a_mem_we;
   logic [15:0] a_mem_addr;
   logic [7:0]  a_mem_wdata, a_mem_rdata;
   int          a_en_cnt = 0;

   // Instance B: READ_LATENCY=4, WAIT_STATES=3
   logic [1:0]  b_req, b_we, b_ready, b_err;
   logic [31:0] b_addr;
   logic [15:0] b_wdata, b_rdata;
   logic        b_mem_en, b_mem_we;
   logic [15:0] b_mem_addr;
   logic [7:0]  b_mem_wdata, b_mem_rdata;
   logic [7:0]  b_pipe [4];
   logic [7:0]  ram_b [256];
   bit          ram_b_vld [256];
   int          b_wr_cnt = 0;

   // Instance C: three masters, round-robin
   logic [2:0]  c_req, c_we, c_ready, c_err;
   logic [47:0] c_addr;
   logic [23:0] c_wdata, c_rdata;
   logic        c_mem_en, c_mem_we;
   logic [15:0] c_mem_addr;
   logic [7:0]  c_mem_wdata, c_mem_rdata;

   sys_bus_ctrl u_a (
      .sys_clk(sys_clk), .reset_n(reset_n), .m_req(a_req), .m_we(a_we), .m_addr(a_addr),
      .m_wdata(a_wdata), .m_rdata(a_rdata), .m_ready(a_ready), .m_proto_err(a_err),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata));

   sys_bus_ctrl #(.READ_LATENCY(4), .WAIT_STATES(3)) u_b (
      .sys_clk(sys_clk), .reset_n(reset_n), .m_req(b_req), .m_we(b_we), .m_addr(b_addr),
      .m_wdata(b_wdata), .m_rdata(b_rdata), .m_ready(b_ready), .m_proto_err(b_err),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));

   sys_bus_ctrl #(.N_MASTERS(3), .ARB_MODE(1)) u_c (
      .sys_clk(sys_clk), .reset_n(reset_n), .m_req(c_req), .m_we(c_we), .m_addr(c_addr),
      .m_wdata(c_wdata), .m_rdata(c_rdata), .m_ready(c_ready), .m_proto_err(c_err),
      .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_addr(c_mem_addr),
      .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata));

   // ROM contents: byte at address a is a[7:0] ^ 0x79 (so 0x0123 -> 0x5A).
   always @(posedge sys_clk) begin
      if (a_mem_en) begin
         a_en_cnt    <= a_en_cnt + 1;
         a_mem_rdata <= a_mem_addr[7:0] ^ 8'h79;
      end
   end

   always @(posedge sys_clk) begin
      if (c_mem_en) c_mem_rdata <= c_mem_addr[7:0] ^ 8'h79;
   end

   always @(posedge sys_clk) begin
      if (b_mem_en && b_mem_we) begin
         ram_b[b_mem_addr[7:0]]     <= b_mem_wdata;
         ram_b_vld[b_mem_addr[7:0]] <= 1'b1;
         b_wr_cnt                   <= b_wr_cnt + 1;
      end
      if (b_mem_en && !b_mem_we)
         b_pipe[0] <= ram_b_vld[b_mem_addr[7:0]] ? ram_b[b_mem_addr[7:0]]
                                                  : (b_mem_addr[7:0] ^ 8'h79);
      for (int k = 1; k < 4; k++) b_pipe[k] <= b_pipe[k-1];
   end
   assign b_mem_rdata = b_pipe[3];

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   // Read on instance B; expects completion 1+4+3 = 8 edges after the request edge.
   task automatic b_read(input int idx, input logic [15:0] addr, input logic [7:0] exp);
      int n;
      b_we[idx]            = 1'b0;
      b_addr[idx*16 +: 16] = addr;
      b_req[idx]           = 1'b1;
      tick();
      b_req = '0;
      n = 0;
      while (!b_ready[idx] && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (n !== 8) $display("FAIL b_read_latency: got %0d edges, expected 8", n);
      else passed++;
      total++;
      if (b_rdata[idx*8 +: 8] !== exp)
         $display("FAIL b_read_data: got %h expected %h", b_rdata[idx*8 +: 8], exp);
      else passed++;
   endtask

   task automatic test_reset;
      #12;
      total++;
      if (a_ready !== 2'b11 || b_ready !== 2'b11 || c_ready !== 3'b111)
         $display("FAIL reset_ready: got %b %b %b expected all ones", a_ready, b_ready, c_ready);
      else passed++;
      total++;
      if (a_rdata !== 16'h0 || a_err !== 2'b00)
         $display("FAIL reset_rdata_err: got %h %b expected 0 00", a_rdata, a_err);
      else passed++;
      total++;
      if (a_mem_en !== 1'b0 || a_mem_we !== 1'b0 || a_mem_addr !== 16'h0 || a_mem_wdata !== 8'h0)
         $display("FAIL reset_mem: got en=%b we=%b addr=%h wd=%h expected zeros",
                  a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
      else passed++;
      @(negedge sys_clk);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_read;
      int c0;
      c0 = a_en_cnt;
      a_addr[15:0] = 16'h0123;
      a_req        = 2'b01;
      tick();
      a_req = '0;
      total++;
      if (a_ready !== 2'b10 || a_mem_en !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 16'h0123)
         $display("FAIL read_edge0: got rdy=%b en=%b we=%b addr=%h expected 10 1 0 0123",
                  a_ready, a_mem_en, a_mem_we, a_mem_addr);
      else passed++;
      tick();
      total++;
      if (a_mem_en !== 1'b0 || a_ready !== 2'b10)
         $display("FAIL read_edge1: got en=%b rdy=%b expected 0 10", a_mem_en, a_ready);
      else passed++;
      tick();
      total++;
      if (a_ready !== 2'b11 || a_rdata !== 16'h005A)
         $display("FAIL read_edge2: got rdy=%b rdata=%h expected 11 005a", a_ready, a_rdata);
      else passed++;
      total++;
      if (a_en_cnt - c0 !== 1)
         $display("FAIL read_access_count: got %0d expected 1", a_en_cnt - c0);
      else passed++;
   endtask

   task automatic test_write_wait;
      int w0;
      b_read(0, 16'h0011, 8'h68);
      w0 = b_wr_cnt;
      b_we[0]       = 1'b1;
      b_addr[15:0]  = 16'h0040;
      b_wdata[7:0]  = 8'hA5;
      b_req         = 2'b01;
      tick();
      b_req = '0;
      b_we  = '0;
      total++;
      if (b_mem_en !== 1'b1 || b_mem_we !== 1'b1 || b_mem_addr !== 16'h0040 || b_mem_wdata !== 8'hA5)
         $display("FAIL write_edge0: got en=%b we=%b addr=%h wd=%h expected 1 1 0040 a5",
                  b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata);
      else passed++;
      tick();
      total++;
      if (b_mem_we !== 1'b0 || b_mem_en !== 1'b0 || b_mem_addr !== 16'h0040)
         $display("FAIL write_edge1: got en=%b we=%b addr=%h expected 0 0 0040",
                  b_mem_en, b_mem_we, b_mem_addr);
      else passed++;
      tick();
      tick();
      total++;
      if (b_ready[0] !== 1'b0)
         $display("FAIL write_edge3: got ready=%b expected 0", b_ready[0]);
      else passed++;
      tick();
      total++;
      if (b_ready[0] !== 1'b1 || b_rdata[7:0] !== 8'h68)
         $display("FAIL write_edge4: got ready=%b rdata=%h expected 1 68", b_ready[0], b_rdata[7:0]);
      else passed++;
      total++;
      if (b_wr_cnt - w0 !== 1 || ram_b[8'h40] !== 8'hA5)
         $display("FAIL write_mem: got writes=%0d data=%h expected 1 a5", b_wr_cnt - w0, ram_b[8'h40]);
      else passed++;
      b_read(1, 16'h0040, 8'hA5);
      total++;
      if (b_rdata[7:0] !== 8'h68)
         $display("FAIL rdata_isolation: got %h expected 68", b_rdata[7:0]);
      else passed++;
   endtask

   task automatic test_simultaneous;
      a_addr = {16'h0020, 16'h0010};
      a_req  = 2'b11;
      tick();
      a_req = '0;
      total++;
      if (a_ready !== 2'b00 || a_mem_en !== 1'b1 || a_mem_addr !== 16'h0010)
         $display("FAIL simul_edge0: got rdy=%b en=%b addr=%h expected 00 1 0010",
                  a_ready, a_mem_en, a_mem_addr);
      else passed++;
      tick();
      tick();
      total++;
      if (a_ready !== 2'b01 || a_rdata[7:0] !== 8'h69 || a_mem_en !== 1'b1 || a_mem_addr !== 16'h0020)
         $display("FAIL simul_edge2: got rdy=%b rd0=%h en=%b addr=%h expected 01 69 1 0020",
                  a_ready, a_rdata[7:0], a_mem_en, a_mem_addr);
      else passed++;
      tick();
      tick();
      total++;
      if (a_ready !== 2'b11 || a_rdata !== 16'h5969)
         $display("FAIL simul_edge4: got rdy=%b rdata=%h expected 11 5969", a_ready, a_rdata);
      else passed++;
   endtask

   task automatic test_proto_err;
      int c0;
      c0 = a_en_cnt;
      a_addr[15:0] = 16'h0030;
      a_req        = 2'b01;
      tick();
      tick();
      a_req = '0;
      total++;
      if (a_err !== 2'b01)
         $display("FAIL proto_err_set: got %b expected 01", a_err);
      else passed++;
      tick();
      tick();
      tick();
      total++;
      if (a_en_cnt - c0 !== 1 || a_err !== 2'b01 || a_rdata[7:0] !== 8'h49)
         $display("FAIL proto_err_sticky: got accesses=%0d err=%b rd0=%h expected 1 01 49",
                  a_en_cnt - c0, a_err, a_rdata[7:0]);
      else passed++;
      // Request landing exactly on master 1's completion edge must be refused.
      a_addr[31:16] = 16'h0031;
      a_req         = 2'b10;
      tick();
      a_req = '0;
      tick();
      a_req = 2'b10;
      tick();
      a_req = '0;
      total++;
      if (a_err !== 2'b11 || a_ready !== 2'b11 || a_mem_en !== 1'b0 || a_rdata[15:8] !== 8'h48)
         $display("FAIL proto_err_completion_edge: got err=%b rdy=%b en=%b rd1=%h expected 11 11 0 48",
                  a_err, a_ready, a_mem_en, a_rdata[15:8]);
      else passed++;
   endtask

   task automatic test_round_robin;
      int   log_q[$];
      int   issued[3];
      int   exp_order[6];
      int   n;
      logic [2:0] r;
      exp_order = '{0, 1, 2, 0, 1, 2};
      issued    = '{1, 0, 0};
      c_addr    = {16'h0082, 16'h0081, 16'h0080};
      c_req     = 3'b001;
      tick();
      n = 0;
      while (log_q.size() < 6 && n < 40) begin
         if (c_mem_en) log_q.push_back(int'(c_mem_addr[1:0]));
         r = '0;
         for (int i = 0; i < 3; i++) begin
            if (c_ready[i] && issued[i] < 2) begin
               r[i] = 1'b1;
               issued[i]++;
            end
         end
         c_req = r;
         tick();
         n++;
      end
      c_req = '0;
      total++;
      if (log_q.size() !== 6)
         $display("FAIL rr_access_count: got %0d expected 6", log_q.size());
      else passed++;
      for (int i = 0; i < 6 && i < log_q.size(); i++) begin
         total++;
         if (log_q[i] !== exp_order[i])
            $display("FAIL rr_order[%0d]: got %0d expected %0d", i, log_q[i], exp_order[i]);
         else passed++;
      end
      n = 0;
      while (c_ready !== 3'b111 && n < 10) begin
         tick();
         n++;
      end
      total++;
      if (c_ready !== 3'b111 || c_rdata !== 24'hFBF8F9 || c_err !== 3'b000)
         $display("FAIL rr_final: got rdy=%b rdata=%h err=%b expected 111 fbf8f9 000",
                  c_ready, c_rdata, c_err);
      else passed++;
   endtask

   task automatic test_reset_mid_wait;
      b_we         = '0;
      b_addr[15:0] = 16'h0050;
      b_req        = 2'b01;
      tick();
      b_req = '0;
      tick();
      tick();
      tick();
      total++;
      if (b_ready[0] !== 1'b0 || b_mem_addr !== 16'h0050)
         $display("FAIL midwait_inflight: got rdy=%b addr=%h expected 0 0050", b_ready[0], b_mem_addr);
      else passed++;
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (b_ready !== 2'b11 || b_rdata !== 16'h0 || b_mem_addr !== 16'h0 || b_mem_en !== 1'b0 || b_err !== 2'b00)
         $display("FAIL midwait_async_reset: got rdy=%b rdata=%h addr=%h en=%b err=%b expected 11 0 0 0 00",
                  b_ready, b_rdata, b_mem_addr, b_mem_en, b_err);
      else passed++;
      @(negedge sys_clk);
      reset_n = 1'b1;
      tick();
      b_read(0, 16'h0012, 8'h6B);
   endtask

   initial begin
      reset_n = 1'b0;
      a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
      b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
      c_req = '0; c_we = '0; c_addr = '0; c_wdata = '0;
      test_reset();
      test_single_read();
      test_write_wait();
      test_simultaneous();
      test_proto_err();
      test_round_robin();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
